tremolo_lfo_probability: RTL and testbench
==========================================

Name: tremolo_lfo_probability

Overview:
- Low-frequency oscillator that produces the "probability of 1" word and the per-sample generate strobe for the biased bitstream generator directly downstream.
- For each audio sample tick it advances a phase accumulator and maps the phase through a selectable waveform (triangle, square or saw-down).
- It scales the waveform by the tremolo depth and emits the result as a probability in [0, TOKENS_FOR_1], with a one-cycle generate_bit_o pulse.
- Rate, depth and shape are updated glitch-free only at a period boundary.

Parameters:
- TOKENS_FOR_1, 2**16, probability scale for 1.0; must be a power of two (elaboration error otherwise).
- PROBABILITY_W, $clog2(TOKENS_FOR_1)+1, non-assignable; width of probability_o, so it can code exactly TOKENS_FOR_1.
- PHASE_W, 24, phase accumulator width; must satisfy PHASE_W-1 >= $clog2(TOKENS_FOR_1).
- DEPTH_W, 8, depth fraction bits; depth value 2**DEPTH_W means 100 %.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  synchronous, active-high reset.
- sample_tick_i  in  1  one-cycle strobe per audio sample; back-to-back ticks are legal.
- cfg_valid_i  in  1  one-cycle strobe; captures rate_i, depth_i and shape_i into the pending registers.
- rate_i  in  PHASE_W  phase increment per sample tick.
- depth_i  in  DEPTH_W+1  modulation depth; values above 2**DEPTH_W are clamped to 2**DEPTH_W.
- shape_i  in  2  waveform select: 0 triangle, 1 square, 2 saw-down, 3 reserved (treated as triangle).
- probability_o  out  PROBABILITY_W  probability word for the bitstream generator.
- generate_bit_o  out  1  one-cycle pulse; probability_o is valid in the same cycle.
- phase_wrap_o  out  1  pulses together with generate_bit_o when that sample's phase wrapped.

Behaviour:
- Reset values: phase 0, active rate 0, active depth 0, active shape triangle, pending flag 0, probability_o = TOKENS_FOR_1, generate_bit_o 0, phase_wrap_o 0. A reset mid-operation flushes the pipeline; no pulse may emerge after it.
- Stage 0, on the edge that samples sample_tick_i = 1:
  - phase <= (phase + rate) mod 2**PHASE_W.
  - wrap = carry out of that addition.
- Waveform w (T = log2 TOKENS_FOR_1; r = phase[PHASE_W-2 -: T]; s = phase[PHASE_W-1 -: T]):
  - triangle: w = r when phase MSB = 0, else w = TOKENS_FOR_1 - r.
  - square: w = TOKENS_FOR_1 when MSB = 0, else w = 0.
  - saw-down: w = TOKENS_FOR_1 - s.
- Stage 1 registers w together with the depth in force for that sample.
- Stage 2 computes the output:
  - m = ((TOKENS_FOR_1 - w) * depth) >> DEPTH_W, with a full-width product of (T+1)+(DEPTH_W+1) bits.
  - probability_o <= TOKENS_FOR_1 - m.
  - generate_bit_o <= 1 and phase_wrap_o <= wrap.
- Latency: generate_bit_o pulses exactly 3 cycles after sample_tick_i. The pipeline accepts one tick per cycle.
- probability_o holds its value between pulses.
- Depth 0 gives a constant TOKENS_FOR_1 (no attenuation).
- Config update rules:
  - cfg_valid_i loads the pending registers and sets the pending flag.
  - A later cfg_valid_i overwrites the pending values (latest wins).
  - Pending values are applied on the edge of a tick whose addition wraps. Rate, depth and shape all change on that same edge.
  - The wrap sample itself was advanced with the old rate, but it is shaped and scaled with the new shape and depth.
  - A cfg_valid_i in the same cycle as a wrapping tick bypasses the pending registers and is applied on that edge.
  - If the active rate is 0, the pending values apply on the next clock edge, tick or not, because a frozen LFO never wraps.
  - When the values are applied, the pending flag clears.

Decomposition:
- tremolo_pkg holds:
  - shape enum (SHAPE_TRI = 0, SHAPE_SQR = 1, SHAPE_SAW = 2);
  - a packed lfo_cfg_t struct {rate, depth, shape};
  - the default TOKENS_FOR_1 constant, shared with biased_bitstream_generator.
- One sub-module, lfo_waveform_lut: combinational phase + shape -> w mapping, reused by future LFO variants.

Test Plan:
- Reset: after srst_i, probability_o = 65536 and generate_bit_o stays 0 with no ticks applied.
- Immediate apply from rate 0: cfg (rate 2**22, depth 256, triangle), then 4 ticks -> probability_o = 32768, 65536, 32768, 0. phase_wrap_o = 1 only on the 4th pulse. Each pulse arrives 3 cycles after its tick.
- Depth and clamp: same config with depth 128 -> 49152, 65536, 49152, 32768. depth_i = 300 behaves exactly as 256.
- Deferred config: while running triangle at rate 2**22, set cfg shape square after tick 1.
  - Ticks 2-3 remain triangle (65536, 32768).
  - Wrap tick 4 outputs square at phase 0 -> 65536.
  - Next tick (phase 2**22) -> 65536; tick after that (phase 2**23) -> 0.
- Same-cycle cfg_valid_i with a wrapping tick, and two cfg_valid_i before a wrap: the latest values apply on that wrap edge.
- Back-to-back ticks for 8 cycles, then srst_i asserted while 2 samples are in flight -> no pulses afterwards, probability_o = 65536.

Source files
------------

// File: rtl/tremolo_lfo_probability_pkg.sv
// Shared types and constants for the tremolo LFO and the biased bitstream
// generator that consumes its probability word.
package tremolo_pkg;

  // Probability scale that represents 1.0; the bitstream generator uses the same value.
  localparam int TOKENS_FOR_1_DEFAULT = 2**16;

  // Default widths of the LFO configuration fields.
  localparam int LFO_PHASE_W = 24;
  localparam int LFO_DEPTH_W = 8;

  // Waveform select. Code 3 is reserved and is shaped as a triangle.
  typedef enum logic [1:0] {
    SHAPE_TRI = 2'd0,
    SHAPE_SQR = 2'd1,
    SHAPE_SAW = 2'd2
  } shape_e;

  // One complete LFO configuration, as captured by a cfg_valid strobe.
  typedef struct packed {
    logic [LFO_PHASE_W-1:0] rate;
    logic [LFO_DEPTH_W:0]   depth;
    logic [1:0]             shape;
  } lfo_cfg_t;

endpackage

// File: rtl/lfo_waveform_lut.sv
// Combinational phase-to-waveform mapping. Only the top T_W+1 phase bits
// matter: the MSB selects the half period, the bits below it form the ramp.
module lfo_waveform_lut
  import tremolo_pkg::*;
#(
  parameter int T_W = 16
) (
  input  logic [T_W:0] i_phaseTop,
  input  logic [1:0]   i_shape,
  output logic [T_W:0] o_wave
);

  localparam logic [T_W:0] FULL = {1'b1, {T_W{1'b0}}};

  logic           w_msb;
  logic [T_W-1:0] w_ramp;
  logic [T_W-1:0] w_saw;

  assign w_msb  = i_phaseTop[T_W];
  assign w_ramp = i_phaseTop[T_W-1:0];
  assign w_saw  = i_phaseTop[T_W:1];

  // Triangle rises over the first half period and falls over the second;
  // square is full then empty; saw-down falls across the whole period.
  always_comb begin
    o_wave = {1'b0, w_ramp};
    case (i_shape)
      SHAPE_SQR: o_wave = w_msb ? '0 : FULL;
      SHAPE_SAW: o_wave = FULL - {1'b0, w_saw};
      default:   o_wave = w_msb ? (FULL - {1'b0, w_ramp}) : {1'b0, w_ramp};
    endcase
  end

endmodule

// File: rtl/tremolo_lfo_probability.sv
// Tremolo LFO: per audio sample it advances a phase accumulator, shapes the
// phase into a waveform, scales it by the depth and emits a probability word
// with a generate strobe three cycles after the sample tick.
module tremolo_lfo_probability
  import tremolo_pkg::*;
#(
  parameter int  TOKENS_FOR_1  = TOKENS_FOR_1_DEFAULT,
  parameter int  PHASE_W       = 24,
  parameter int  DEPTH_W       = 8,
  localparam int PROBABILITY_W = $clog2(TOKENS_FOR_1) + 1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     sample_tick_i,
  input  logic                     cfg_valid_i,
  input  logic [PHASE_W-1:0]       rate_i,
  input  logic [DEPTH_W:0]         depth_i,
  input  logic [1:0]               shape_i,
  output logic [PROBABILITY_W-1:0] probability_o,
  output logic                     generate_bit_o,
  output logic                     phase_wrap_o
);

  localparam int T_W    = PROBABILITY_W - 1;
  localparam int PROD_W = PROBABILITY_W + DEPTH_W + 1;

  localparam logic [PROBABILITY_W-1:0] FULL      = {1'b1, {T_W{1'b0}}};
  localparam logic [DEPTH_W:0]         DEPTH_MAX = {1'b1, {DEPTH_W{1'b0}}};

  if ((TOKENS_FOR_1 < 2) || ((TOKENS_FOR_1 & (TOKENS_FOR_1 - 1)) != 0)) begin : g_badTokens
    $error("TOKENS_FOR_1 must be a power of two");
  end
  if (PHASE_W - 1 < T_W) begin : g_badPhaseW
    $error("PHASE_W too narrow for TOKENS_FOR_1");
  end

  // Active and pending configuration
  logic [PHASE_W-1:0] r_activeRate;
  logic [DEPTH_W:0]   r_activeDepth;
  logic [1:0]         r_activeShape;
  logic [PHASE_W-1:0] r_pendRate;
  logic [DEPTH_W:0]   r_pendDepth;
  logic [1:0]         r_pendShape;
  logic               r_pendValid;

  // Pipeline
  logic [PHASE_W-1:0]       r_phase;
  logic                     r_s0Valid;
  logic                     r_s0Wrap;
  logic [PROBABILITY_W-1:0] r_s1Wave;
  logic [DEPTH_W:0]         r_s1Depth;
  logic                     r_s1Valid;
  logic                     r_s1Wrap;
  logic [PROBABILITY_W-1:0] r_prob;
  logic                     r_gen;
  logic                     r_wrap;

  logic [PHASE_W:0]         w_sum;
  logic                     w_carry;
  logic                     w_wrapEdge;
  logic                     w_rateZero;
  logic                     w_useInputs;
  logic                     w_usePending;
  logic [DEPTH_W:0]         w_depthClamped;
  logic [PROBABILITY_W-1:0] w_wave;
  logic [PROBABILITY_W-1:0] w_atten;
  logic [PROD_W-1:0]        w_product;

  assign w_sum      = {1'b0, r_phase} + {1'b0, r_activeRate};
  assign w_carry    = w_sum[PHASE_W];
  assign w_wrapEdge = sample_tick_i && w_carry;
  assign w_rateZero = (r_activeRate == '0);

  // A new config arriving on an edge where config may be applied wins over
  // anything pending; a frozen LFO (rate 0) would never wrap, so it applies
  // its pending config on the very next edge.
  assign w_useInputs  = cfg_valid_i && (w_wrapEdge || (w_rateZero && r_pendValid));
  assign w_usePending = !w_useInputs && r_pendValid && (w_wrapEdge || w_rateZero);

  assign w_depthClamped = (depth_i > DEPTH_MAX) ? DEPTH_MAX : depth_i;

  // Capture new config into pending and swap it into the active set on a period boundary
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_activeRate  <= '0;
      r_activeDepth <= '0;
      r_activeShape <= SHAPE_TRI;
      r_pendRate    <= '0;
      r_pendDepth   <= '0;
      r_pendShape   <= SHAPE_TRI;
      r_pendValid   <= 1'b0;
    end else begin
      if (w_useInputs) begin
        r_activeRate  <= rate_i;
        r_activeDepth <= w_depthClamped;
        r_activeShape <= shape_i;
        r_pendValid   <= 1'b0;
      end else if (w_usePending) begin
        r_activeRate  <= r_pendRate;
        r_activeDepth <= r_pendDepth;
        r_activeShape <= r_pendShape;
        r_pendValid   <= 1'b0;
      end
      if (cfg_valid_i && !w_useInputs) begin
        r_pendRate  <= rate_i;
        r_pendDepth <= w_depthClamped;
        r_pendShape <= shape_i;
        r_pendValid <= 1'b1;
      end
    end
  end

  // Stage 0: advance the phase on each sample tick and remember whether it wrapped
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_phase   <= '0;
      r_s0Valid <= 1'b0;
      r_s0Wrap  <= 1'b0;
    end else begin
      r_s0Valid <= sample_tick_i;
      if (sample_tick_i) begin
        r_phase  <= w_sum[PHASE_W-1:0];
        r_s0Wrap <= w_carry;
      end
    end
  end

  lfo_waveform_lut #(
    .T_W (T_W)
  ) u_lut (
    .i_phaseTop (r_phase[PHASE_W-1 -: T_W+1]),
    .i_shape    (r_activeShape),
    .o_wave     (w_wave)
  );

  // Stage 1: register the shaped waveform with the depth in force for this sample
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_s1Wave  <= '0;
      r_s1Depth <= '0;
      r_s1Valid <= 1'b0;
      r_s1Wrap  <= 1'b0;
    end else begin
      r_s1Valid <= r_s0Valid;
      if (r_s0Valid) begin
        r_s1Wave  <= w_wave;
        r_s1Depth <= r_activeDepth;
        r_s1Wrap  <= r_s0Wrap;
      end
    end
  end

  assign w_atten   = FULL - r_s1Wave;
  assign w_product = PROD_W'(w_atten) * PROD_W'(r_s1Depth);

  // Stage 2: attenuate 1.0 by depth-scaled (1 - w) and hold the result between pulses
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_prob <= FULL;
      r_gen  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_gen  <= r_s1Valid;
      r_wrap <= r_s1Valid && r_s1Wrap;
      if (r_s1Valid) begin
        r_prob <= FULL - PROBABILITY_W'(w_product >> DEPTH_W);
      end
    end
  end

  assign probability_o  = r_prob;
  assign generate_bit_o = r_gen;
  assign phase_wrap_o   = r_wrap;

endmodule

// File: tb/tb_tremolo_lfo_probability.sv
// Directed bench for tremolo_lfo_probability with hand-computed expectations.
module tb_tremolo_lfo_probability;
  import tremolo_pkg::*;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b1;
  logic        sample_tick_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic [23:0] rate_i = '0;
  logic [8:0]  depth_i = '0;
  logic [1:0]  shape_i = '0;
  logic [16:0] probability_o;
  logic        generate_bit_o;
  logic        phase_wrap_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  tremolo_lfo_probability dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .sample_tick_i  (sample_tick_i),
    .cfg_valid_i    (cfg_valid_i),
    .rate_i         (rate_i),
    .depth_i        (depth_i),
    .shape_i        (shape_i),
    .probability_o  (probability_o),
    .generate_bit_o (generate_bit_o),
    .phase_wrap_o   (phase_wrap_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetDut();
    srst_i = 1'b1;
    sample_tick_i = 1'b0;
    cfg_valid_i = 1'b0;
    step();
    step();
    srst_i = 1'b0;
  endtask

  task automatic applyCfg(input logic [23:0] rate, input logic [8:0] depth, input logic [1:0] shape);
    rate_i = rate;
    depth_i = depth;
    shape_i = shape;
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
    step();
  endtask

  // One tick; reports any pulse seen before the third cycle and the outputs on it.
  task automatic runTick(output logic [16:0] prob, output logic early, output logic gen, output logic wrap);
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    cfg_valid_i = 1'b0;
    early = generate_bit_o;
    step();
    early = early | generate_bit_o;
    step();
    gen = generate_bit_o;
    prob = probability_o;
    wrap = phase_wrap_o;
  endtask

  task automatic test_reset();
    resetDut();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (generate_bit_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_gen[%0d]: got %b, want 0", i, generate_bit_o);
      end
      checks++;
      if (probability_o !== 17'd65536) begin
        errors++;
        $display("[TB] FAIL reset_prob[%0d]: got %0d, want 65536", i, probability_o);
      end
    end
    checks++;
    if (phase_wrap_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wrap: got %b, want 0", phase_wrap_o);
    end
  endtask

  task automatic test_immediate_apply();
    logic [16:0] expP [4];
    logic        expW [4];
    logic [16:0] p;
    logic        e, g, w;
    expP = '{17'd32768, 17'd65536, 17'd32768, 17'd0};
    expW = '{1'b0, 1'b0, 1'b0, 1'b1};
    resetDut();
    applyCfg(24'h400000, 9'd256, SHAPE_TRI);
    for (int n = 0; n < 4; n++) begin
      runTick(p, e, g, w);
      checks++;
      if (e !== 1'b0 || g !== 1'b1) begin
        errors++;
        $display("[TB] FAIL imm_latency[%0d]: got early=%b pulse=%b, want early=0 pulse=1", n, e, g);
      end
      checks++;
      if (p !== expP[n]) begin
        errors++;
        $display("[TB] FAIL imm_prob[%0d]: got %0d, want %0d", n, p, expP[n]);
      end
      checks++;
      if (w !== expW[n]) begin
        errors++;
        $display("[TB] FAIL imm_wrap[%0d]: got %b, want %b", n, w, expW[n]);
      end
    end
  endtask

  task automatic test_depth_clamp();
    logic [16:0] expHalf [4];
    logic [16:0] expFull [4];
    logic [16:0] want;
    logic [16:0] p;
    logic        e, g, w;
    expHalf = '{17'd49152, 17'd65536, 17'd49152, 17'd32768};
    expFull = '{17'd32768, 17'd65536, 17'd32768, 17'd0};
    for (int run = 0; run < 2; run++) begin
      resetDut();
      applyCfg(24'h400000, (run == 0) ? 9'd128 : 9'd300, SHAPE_TRI);
      for (int n = 0; n < 4; n++) begin
        runTick(p, e, g, w);
        want = (run == 0) ? expHalf[n] : expFull[n];
        checks++;
        if (g !== 1'b1 || p !== want) begin
          errors++;
          $display("[TB] FAIL depth_run%0d[%0d]: got pulse=%b prob=%0d, want pulse=1 prob=%0d", run, n, g, p, want);
        end
      end
    end
  endtask

  task automatic test_deferred_cfg();
    logic [16:0] expP [5];
    logic        expW [5];
    logic [16:0] p;
    logic        e, g, w;
    expP = '{17'd65536, 17'd32768, 17'd65536, 17'd65536, 17'd0};
    expW = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    resetDut();
    applyCfg(24'h400000, 9'd256, SHAPE_TRI);
    runTick(p, e, g, w);
    checks++;
    if (p !== 17'd32768) begin
      errors++;
      $display("[TB] FAIL defer_tick1: got %0d, want 32768", p);
    end
    applyCfg(24'h400000, 9'd256, SHAPE_SQR);
    checks++;
    if (generate_bit_o !== 1'b0 || probability_o !== 17'd32768) begin
      errors++;
      $display("[TB] FAIL defer_hold: got pulse=%b prob=%0d, want pulse=0 prob=32768", generate_bit_o, probability_o);
    end
    for (int n = 0; n < 5; n++) begin
      runTick(p, e, g, w);
      checks++;
      if (g !== 1'b1 || p !== expP[n] || w !== expW[n]) begin
        errors++;
        $display("[TB] FAIL defer_tick%0d: got pulse=%b prob=%0d wrap=%b, want pulse=1 prob=%0d wrap=%b",
                 n + 2, g, p, w, expP[n], expW[n]);
      end
    end
  endtask

  task automatic test_same_cycle_and_latest();
    logic [16:0] expP [14];
    logic        expW [14];
    logic [16:0] p;
    logic        e, g, w;
    expP = '{17'd32768, 17'd65536, 17'd32768, 17'd65536, 17'd57344, 17'd49152, 17'd40960,
             17'd32768, 17'd24576, 17'd16384, 17'd8192, 17'd65536, 17'd65536, 17'd0};
    expW = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    resetDut();
    applyCfg(24'h400000, 9'd256, SHAPE_TRI);
    for (int n = 0; n < 14; n++) begin
      if (n == 3) begin
        rate_i = 24'h200000;
        depth_i = 9'd256;
        shape_i = SHAPE_SAW;
        cfg_valid_i = 1'b1;
      end
      if (n == 5) begin
        applyCfg(24'h400000, 9'd128, SHAPE_TRI);
        applyCfg(24'h400000, 9'd256, SHAPE_SQR);
      end
      runTick(p, e, g, w);
      checks++;
      if (e !== 1'b0 || g !== 1'b1 || p !== expP[n] || w !== expW[n]) begin
        errors++;
        $display("[TB] FAIL cfg_tick%0d: got early=%b pulse=%b prob=%0d wrap=%b, want early=0 pulse=1 prob=%0d wrap=%b",
                 n, e, g, p, w, expP[n], expW[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] triP [4];
    logic [16:0] wantP;
    logic        wantW;
    int          sampleNo;
    triP = '{17'd32768, 17'd65536, 17'd32768, 17'd0};
    resetDut();
    applyCfg(24'h400000, 9'd256, SHAPE_TRI);
    sample_tick_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) begin
        sample_tick_i = 1'b0;
      end
      if (i < 3) begin
        checks++;
        if (generate_bit_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_early[%0d]: got pulse=%b, want 0", i, generate_bit_o);
        end
      end else begin
        sampleNo = i - 2;
        wantP = triP[(sampleNo - 1) % 4];
        wantW = (sampleNo % 4) == 0;
        checks++;
        if (generate_bit_o !== 1'b1 || probability_o !== wantP || phase_wrap_o !== wantW) begin
          errors++;
          $display("[TB] FAIL b2b_sample%0d: got pulse=%b prob=%0d wrap=%b, want pulse=1 prob=%0d wrap=%b",
                   sampleNo, generate_bit_o, probability_o, phase_wrap_o, wantP, wantW);
        end
      end
    end
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (generate_bit_o !== 1'b0 || probability_o !== 17'd65536) begin
        errors++;
        $display("[TB] FAIL b2b_flush[%0d]: got pulse=%b prob=%0d, want pulse=0 prob=65536",
                 i, generate_bit_o, probability_o);
      end
      step();
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_immediate_apply();
    test_depth_clamp();
    test_deferred_cfg();
    test_same_cycle_and_latest();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
